if_unit_gen2: RTL and testbench

//  Parametrised instruction-fetch / program-counter unit, successor to the 16-bit IF stage.

---
 rtl/if_unit_gen2.sv | 175 +++++++++++++++++
 tb/tb_if_unit_gen2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit_gen2.sv
// if_unit_gen2: parametrised instruction-fetch / program-counter unit.
// Drives the instruction-memory address (PC). The run/halt FSM moves through
// IDLE, RUN and HALT. Branch controls come from decode and ALU_zero from the ALU.
// Optional feature macro IF_RAS_EN adds a call/return address stack and the
// Call, Ret and Ras_err behaviour. When the macro is undefined, Call and Ret are
// ignored and Ras_err is tied low.
module if_unit_gen2 #(
    parameter int PC_W      = 16,
    parameter int START_PC  = 0,
    parameter int DONE_PC   = 300,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Init_n,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Branch_abs,
    input  logic            Branch_rel_z,
    input  logic            Branch_rel_nz,
    input  logic            ALU_zero,
    input  logic            Call,
    input  logic            Ret,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] PC,
    output logic            DONE,
    output logic            Ras_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_VAL = PC_W'(START_PC);
    localparam logic [PC_W-1:0] DONE_VAL  = PC_W'(DONE_PC);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            done_nxt;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_rel;

    // Both sums wrap modulo 2^PC_W; Target doubles as a two's-complement offset.
    assign pc_plus1 = PC + PC_W'(1);
    assign pc_rel   = PC + Target;

`ifdef IF_RAS_EN
    // The pointer counts 0..RAS_DEPTH. Storage is indexed by the low bits of the
    // pointer, which stay in range whenever the pointer is below RAS_DEPTH.
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int SLOTS = 2 ** IDX_W;

    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_m1;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [PC_W-1:0]  ras_mem [SLOTS];
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;
    logic             err_set;

    assign sp_m1     = sp - SP_W'(1);
    assign push_idx  = sp[IDX_W-1:0];
    assign pop_idx   = sp_m1[IDX_W-1:0];
    assign ras_full  = (sp == SP_W'(RAS_DEPTH));
    assign ras_empty = (sp == '0);
`else
    // Without the stack, Call, Ret and RAS_DEPTH have no function.
    logic unused_ras;
    assign unused_ras = Call | Ret | (RAS_DEPTH < 1);
    assign Ras_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge Init_n) begin
        // NOTE: clocked state uses non-blocking assignments so that every register samples pre-edge values.
        if (!Init_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: Start wins everywhere; RUN halts on reaching DONE_PC.
    always_comb begin
        // NOTE: defaulting every comb output first keeps the block free of inferred latches.
        state_nxt = state;
        if (Start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (PC == DONE_VAL) state_nxt = HALT;
                default: state_nxt = state;
            endcase
        end
    end

    // Output logic: next PC, DONE, and stack operations in the priority order.
    always_comb begin
        pc_nxt   = PC;
        done_nxt = (state_nxt == HALT);
`ifdef IF_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        err_set  = 1'b0;
`endif
        if (Start) begin
            pc_nxt = START_VAL;
        end else if (state == RUN && PC != DONE_VAL) begin
            if (Stall) begin
                pc_nxt = PC;
            end else if (Branch_abs) begin
                pc_nxt = Target;
`ifdef IF_RAS_EN
            end else if (Call) begin
                // The jump is taken even when the push has to be dropped.
                pc_nxt = Target;
                if (ras_full) err_set = 1'b1;
                else          push    = 1'b1;
            end else if (Ret) begin
                if (ras_empty) begin
                    pc_nxt  = pc_plus1;
                    err_set = 1'b1;
                end else begin
                    pc_nxt = ras_mem[pop_idx];
                    pop    = 1'b1;
                end
`endif
            end else if (Branch_rel_z && ALU_zero) begin
                pc_nxt = pc_rel;
            end else if (Branch_rel_nz && !ALU_zero) begin
                pc_nxt = pc_rel;
            end else begin
                pc_nxt = pc_plus1;
            end
        end
    end

    // PC and DONE registers.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            PC   <= START_VAL;
            DONE <= 1'b0;
        end else begin
            PC   <= pc_nxt;
            DONE <= done_nxt;
        end
    end

`ifdef IF_RAS_EN
    // Stack pointer and sticky error flag; Start deliberately leaves both alone.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            sp      <= '0;
            Ras_err <= 1'b0;
        end else begin
            if (push)      sp <= sp + SP_W'(1);
            else if (pop)  sp <= sp_m1;
            if (err_set)   Ras_err <= 1'b1;
        end
    end

    // Return-address storage; a pop leaves the old entry in place.
    always_ff @(posedge CLK) begin
        // NOTE: entries carry no reset; the pointer alone defines which entries are valid.
        if (push) ras_mem[push_idx] <= pc_plus1;
    end
`endif

endmodule

// File: tb/tb_if_unit_gen2.sv
// Directed testbench for if_unit_gen2 using the default parameters.
// Call and Ret expectations depend on whether IF_RAS_EN is defined.
module tb_if_unit_gen2;

    localparam int PC_W = 16;
`ifdef IF_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic            CLK           = 1'b0;
    logic            Init_n        = 1'b0;
    logic            Start         = 1'b0;
    logic            Stall         = 1'b0;
    logic            Branch_abs    = 1'b0;
    logic            Branch_rel_z  = 1'b0;
    logic            Branch_rel_nz = 1'b0;
    logic            ALU_zero      = 1'b0;
    logic            Call          = 1'b0;
    logic            Ret           = 1'b0;
    logic [PC_W-1:0] Target        = '0;
    logic [PC_W-1:0] PC;
    logic            DONE;
    logic            Ras_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    if_unit_gen2 dut (
        .CLK           (CLK),
        .Init_n        (Init_n),
        .Start         (Start),
        .Stall         (Stall),
        .Branch_abs    (Branch_abs),
        .Branch_rel_z  (Branch_rel_z),
        .Branch_rel_nz (Branch_rel_nz),
        .ALU_zero      (ALU_zero),
        .Call          (Call),
        .Ret           (Ret),
        .Target        (Target),
        .PC            (PC),
        .DONE          (DONE),
        .Ras_err       (Ras_err)
    );

    // Advance one edge and settle past it; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 1'b0; Stall = 1'b0; Branch_abs = 1'b0; Branch_rel_z = 1'b0;
        Branch_rel_nz = 1'b0; ALU_zero = 1'b0; Call = 1'b0; Ret = 1'b0; Target = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Init_n = 1'b0;
        #2;
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", PC); end
        n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", DONE); end
        n_cmp++; if (Ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_ras_err: got %b want 0", Ras_err); end
        #10 Init_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL idle_hold: got %0d want 0", PC); end
    endtask

    task automatic test_sequential();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL start_pc: got %0d want 0", PC); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (PC !== 16'(i)) begin n_bad++; $display("FAIL seq_pc[%0d]: got %0d want %0d", i, PC, i); end
            n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL seq_done[%0d]: got %b want 0", i, DONE); end
        end
    endtask

    task automatic test_branches();
        Branch_abs = 1'b1; Target = 16'd10; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd10) begin n_bad++; $display("FAIL abs_10: got %0d want 10", PC); end
        Branch_rel_z = 1'b1; ALU_zero = 1'b1; Target = 16'hFFFD; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd7) begin n_bad++; $display("FAIL rel_z_taken: got %0d want 7", PC); end
        Branch_abs = 1'b1; Target = 16'd10; tick(); idle_inputs();
        Branch_rel_z = 1'b1; ALU_zero = 1'b0; Target = 16'hFFFD; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd11) begin n_bad++; $display("FAIL rel_z_not_taken: got %0d want 11", PC); end
        Branch_rel_nz = 1'b1; ALU_zero = 1'b0; Target = 16'd5; tick();
        n_cmp++; if (PC !== 16'd16) begin n_bad++; $display("FAIL rel_nz_taken: got %0d want 16", PC); end
        ALU_zero = 1'b1; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd17) begin n_bad++; $display("FAIL rel_nz_not_taken: got %0d want 17", PC); end
        Stall = 1'b1; Branch_abs = 1'b1; Target = 16'd99; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd17) begin n_bad++; $display("FAIL stall_hold: got %0d want 17", PC); end
        Branch_abs = 1'b1; Branch_rel_z = 1'b1; ALU_zero = 1'b1; Target = 16'd20; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd20) begin n_bad++; $display("FAIL abs_over_rel: got %0d want 20", PC); end
        Branch_abs = 1'b1; Target = 16'hFFFF; tick(); idle_inputs();
        tick();
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL inc_wrap: got %0d want 0", PC); end
        Branch_rel_z = 1'b1; ALU_zero = 1'b1; Target = 16'hFFFF; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'hFFFF) begin n_bad++; $display("FAIL rel_wrap: got %0d want 65535", PC); end
    endtask

    task automatic test_halt();
        Branch_abs = 1'b1; Target = 16'd298; tick(); idle_inputs();
        tick();
        tick();
        n_cmp++; if (PC !== 16'd300) begin n_bad++; $display("FAIL reach_300: got %0d want 300", PC); end
        n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b want 0", DONE); end
        Branch_abs = 1'b1; Target = 16'd5; tick();
        n_cmp++; if (PC !== 16'd300) begin n_bad++; $display("FAIL halt_pc: got %0d want 300", PC); end
        n_cmp++; if (DONE !== 1'b1) begin n_bad++; $display("FAIL halt_done: got %b want 1", DONE); end
        tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd300) begin n_bad++; $display("FAIL halt_ignore_abs: got %0d want 300", PC); end
        Start = 1'b1; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL restart_pc: got %0d want 0", PC); end
        n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", DONE); end
        tick();
        n_cmp++; if (PC !== 16'd1) begin n_bad++; $display("FAIL restart_run: got %0d want 1", PC); end
    endtask

    task automatic test_call_ret();
        logic [PC_W-1:0] exp;
        Branch_abs = 1'b1; Target = 16'd5; tick(); idle_inputs();
        Call = 1'b1; Target = 16'd40; tick(); idle_inputs();
        exp = RAS ? 16'd40 : 16'd6;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL call_jump: got %0d want %0d", PC, exp); end
        Ret = 1'b1; tick();
        exp = RAS ? 16'd6 : 16'd7;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL ret_pop: got %0d want %0d", PC, exp); end
        n_cmp++; if (Ras_err !== 1'b0) begin n_bad++; $display("FAIL ret_no_err: got %b want 0", Ras_err); end
        tick(); idle_inputs();
        exp = RAS ? 16'd7 : 16'd8;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL ret_empty_pc: got %0d want %0d", PC, exp); end
        n_cmp++; if (Ras_err !== RAS) begin n_bad++; $display("FAIL ret_empty_err: got %b want %b", Ras_err, RAS); end
        Stall = 1'b1; Call = 1'b1; Target = 16'd99; tick(); idle_inputs();
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL stall_call: got %0d want %0d", PC, exp); end
        Ret = 1'b1; tick(); idle_inputs();
        exp = exp + 16'd1;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL stall_no_push: got %0d want %0d", PC, exp); end
        Start = 1'b1; tick(); idle_inputs();
        n_cmp++; if (Ras_err !== RAS) begin n_bad++; $display("FAIL start_keeps_err: got %b want %b", Ras_err, RAS); end
    endtask

    task automatic test_ras_nesting();
        logic [PC_W-1:0] tgt [4] = '{16'd41, 16'd81, 16'd121, 16'd161};
        logic [PC_W-1:0] rtn [4] = '{16'd122, 16'd82, 16'd42, 16'd2};
        logic [PC_W-1:0] exp;
        Init_n = 1'b0; #2; Init_n = 1'b1;
        Start = 1'b1; tick(); idle_inputs();
        tick();
        for (int i = 0; i < 4; i++) begin
            Call = 1'b1; Target = tgt[i]; tick();
            exp = RAS ? tgt[i] : 16'(2 + i);
            n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL nest_call[%0d]: got %0d want %0d", i, PC, exp); end
        end
        idle_inputs();
        n_cmp++; if (Ras_err !== 1'b0) begin n_bad++; $display("FAIL nest_full_no_err: got %b want 0", Ras_err); end
        for (int i = 0; i < 4; i++) begin
            Ret = 1'b1; tick();
            exp = RAS ? rtn[i] : 16'(6 + i);
            n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL nest_ret[%0d]: got %0d want %0d", i, PC, exp); end
        end
        Call = 1'b1; Ret = 1'b1; Target = 16'd100; tick(); idle_inputs();
        exp = RAS ? 16'd100 : 16'd10;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL call_and_ret: got %0d want %0d", PC, exp); end
        Ret = 1'b1; tick(); idle_inputs();
        exp = RAS ? 16'd3 : 16'd11;
        n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL ret_after_both: got %0d want %0d", PC, exp); end
        n_cmp++; if (Ras_err !== 1'b0) begin n_bad++; $display("FAIL nest_err_clear: got %b want 0", Ras_err); end
    endtask

    task automatic test_ras_overflow();
        logic [PC_W-1:0] exp;
        logic            exp_err;
        for (int i = 0; i < 5; i++) begin
            Call = 1'b1; Target = 16'(41 + 40 * i); tick();
            exp     = RAS ? 16'(41 + 40 * i) : 16'(12 + i);
            exp_err = RAS && (i == 4);
            n_cmp++; if (PC !== exp) begin n_bad++; $display("FAIL ovf_call[%0d]: got %0d want %0d", i, PC, exp); end
            n_cmp++; if (Ras_err !== exp_err) begin n_bad++; $display("FAIL ovf_err[%0d]: got %b want %b", i, Ras_err, exp_err); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        Branch_abs = 1'b1; Target = 16'd13; tick(); idle_inputs();
        n_cmp++; if (PC !== 16'd13) begin n_bad++; $display("FAIL pre_reset_pc: got %0d want 13", PC); end
        Stall = 1'b1;
        @(negedge CLK);
        #1 Init_n = 1'b0;
        #1;
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL async_pc: got %0d want 0", PC); end
        n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL async_done: got %b want 0", DONE); end
        n_cmp++; if (Ras_err !== 1'b0) begin n_bad++; $display("FAIL async_ras_err: got %b want 0", Ras_err); end
        #1 Init_n = 1'b1;
        tick();
        Stall = 1'b0;
        tick();
        n_cmp++; if (PC !== 16'd0) begin n_bad++; $display("FAIL post_reset_idle: got %0d want 0", PC); end
        Start = 1'b1; tick(); idle_inputs();
        tick();
        n_cmp++; if (PC !== 16'd1) begin n_bad++; $display("FAIL post_reset_run: got %0d want 1", PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_halt();
        test_call_ret();
        test_ras_nesting();
        test_ras_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
